// File: rtl/cache_fill_ctrl.sv
// Miss-handling sequencer: latches the victim way, writes it back if dirty,
// fetches the new line beat by beat, then commits valid/LRU updates.
module cache_fill_ctrl #(
    parameter int NUMWAYS      = 4,
    parameter int BEATSPERLINE = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              Miss,
    input  logic                              FlushStage,
    input  logic                              InvalidateCache,
    input  logic [NUMWAYS-1:0]                VictimWay,
    input  logic                              VictimDirty,
    input  logic                              BusAck,
    output logic                              BusReq,
    output logic                              BusWrite,
    output logic [$clog2(BEATSPERLINE)-1:0]   BeatCount,
    output logic [NUMWAYS-1:0]                FillWay,
    output logic                              FillWordEn,
    output logic                              ClearValid,
    output logic                              SetValid,
    output logic                              LRUWriteEn,
    output logic                              Stall
);

    // state     | meaning
    // IDLE      | no miss in flight, pipeline runs
    // WRITEBACK | streaming dirty victim line out to the bus
    // FETCH     | streaming the new line in from the bus
    // COMMIT    | one cycle: mark line valid, update replacement state

    localparam int BEATLEN = $clog2(BEATSPERLINE);
    localparam logic [BEATLEN-1:0] LAST_BEAT = BEATLEN'(BEATSPERLINE - 1);
    localparam logic [BEATLEN-1:0] BEAT_ONE  = BEATLEN'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BEATLEN-1:0]   beat_q, beat_d;
    logic [NUMWAYS-1:0]   fill_way_q, fill_way_d;
    logic                 inv_pend_q, inv_pend_d;
    logic                 first_fetch_q, first_fetch_d;

    logic launch;
    logic last_beat;

    assign launch    = Miss & ~FlushStage & ~InvalidateCache;
    assign last_beat = (beat_q == LAST_BEAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            fill_way_q    <= '0;
            inv_pend_q    <= 1'b0;
            first_fetch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            fill_way_q    <= fill_way_d;
            inv_pend_q    <= inv_pend_d;
            first_fetch_q <= first_fetch_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        fill_way_d    = fill_way_q;
        inv_pend_d    = inv_pend_q;
        first_fetch_d = 1'b0;
        case (state_q)
            IDLE: begin
                inv_pend_d = 1'b0;
                if (launch) begin
                    fill_way_d = VictimWay;
                    beat_d     = '0;
                    if (VictimDirty) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d       = FETCH;
                        first_fetch_d = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                inv_pend_d = inv_pend_q | InvalidateCache;
                if (BusAck) begin
                    if (last_beat) begin
                        beat_d        = '0;
                        state_d       = FETCH;
                        first_fetch_d = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end
            FETCH: begin
                // An invalidate racing the last beat must still suppress the commit.
                inv_pend_d = inv_pend_q | InvalidateCache;
                if (BusAck) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = COMMIT;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end
            COMMIT: begin
                state_d    = IDLE;
                inv_pend_d = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                inv_pend_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        BusReq     = 1'b0;
        BusWrite   = 1'b0;
        FillWordEn = 1'b0;
        SetValid   = 1'b0;
        LRUWriteEn = 1'b0;
        Stall      = 1'b1;
        BeatCount  = beat_q;
        FillWay    = fill_way_q;
        ClearValid = first_fetch_q;
        case (state_q)
            IDLE: begin
                Stall = 1'b0;
            end
            WRITEBACK: begin
                BusReq   = 1'b1;
                BusWrite = 1'b1;
            end
            FETCH: begin
                BusReq     = 1'b1;
                FillWordEn = BusAck;
            end
            COMMIT: begin
                SetValid   = ~inv_pend_q;
                LRUWriteEn = ~inv_pend_q & ~FlushStage;
            end
            default: begin
                Stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed, table-driven bench for cache_fill_ctrl (4 ways, 4 beats per line).
module tb_cache_fill_ctrl;

    localparam int NW = 4;
    localparam int BL = 4;

    logic          clk;
    logic          reset;
    logic          Miss;
    logic          FlushStage;
    logic          InvalidateCache;
    logic [NW-1:0] VictimWay;
    logic          VictimDirty;
    logic          BusAck;
    logic          BusReq;
    logic          BusWrite;
    logic [1:0]    BeatCount;
    logic [NW-1:0] FillWay;
    logic          FillWordEn;
    logic          ClearValid;
    logic          SetValid;
    logic          LRUWriteEn;
    logic          Stall;

    int checks   = 0;
    int failures = 0;

    cache_fill_ctrl #(.NUMWAYS(NW), .BEATSPERLINE(BL)) dut (
        .clk            (clk),
        .reset          (reset),
        .Miss           (Miss),
        .FlushStage     (FlushStage),
        .InvalidateCache(InvalidateCache),
        .VictimWay      (VictimWay),
        .VictimDirty    (VictimDirty),
        .BusAck         (BusAck),
        .BusReq         (BusReq),
        .BusWrite       (BusWrite),
        .BeatCount      (BeatCount),
        .FillWay        (FillWay),
        .FillWordEn     (FillWordEn),
        .ClearValid     (ClearValid),
        .SetValid       (SetValid),
        .LRUWriteEn     (LRUWriteEn),
        .Stall          (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A launch with a non-one-hot victim is a caller error.
    always @(posedge clk) begin
        if (reset && !Stall && Miss && !FlushStage && !InvalidateCache)
            assert ($onehot(VictimWay)) else $error("non-one-hot VictimWay at launch: %b", VictimWay);
    end

    typedef struct {
        string      name;
        logic       miss, flush, inval;
        logic [3:0] vway;
        logic       dirty, ack;
        logic       breq, bwr;
        logic [1:0] beat;
        logic [3:0] fway;
        logic       fwe, cv, sv, lru, stall;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [12:0] outs_now();
        return {BusReq, BusWrite, BeatCount, FillWay, FillWordEn, ClearValid, SetValid, LRUWriteEn, Stall};
    endfunction

    task automatic check13(input string nm, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got breq,bwr,beat,fway,fwe,cv,sv,lru,stall=%b want %b", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic add(input string nm, input logic mi, input logic fl, input logic iv,
                       input logic [3:0] vw, input logic di, input logic ak,
                       input logic br, input logic bw, input logic [1:0] bt, input logic [3:0] fw,
                       input logic fe, input logic c, input logic s, input logic l, input logic st);
        vec_t v;
        v.name = nm; v.miss = mi; v.flush = fl; v.inval = iv; v.vway = vw; v.dirty = di; v.ack = ak;
        v.breq = br; v.bwr = bw; v.beat = bt; v.fway = fw; v.fwe = fe; v.cv = c; v.sv = s; v.lru = l;
        v.stall = st;
        vecs.push_back(v);
    endtask

    task automatic idle_row(input string nm, input logic mi, input logic fl, input logic iv,
                            input logic [3:0] vw, input logic di, input logic [3:0] fw);
        add(nm, mi, fl, iv, vw, di, 1'b1, 0, 0, 2'd0, fw, 0, 0, 0, 0, 0);
    endtask

    task automatic wb_row(input string nm, input logic iv, input logic ak, input int bt, input logic [3:0] fw);
        add(nm, 0, 0, iv, 4'b0000, 0, ak, 1, 1, 2'(bt), fw, 0, 0, 0, 0, 1);
    endtask

    task automatic fetch_row(input string nm, input logic mi, input logic iv, input logic [3:0] vw,
                             input logic ak, input int bt, input logic [3:0] fw, input logic c);
        add(nm, mi, 0, iv, vw, 0, ak, 1, 0, 2'(bt), fw, ak, c, 0, 0, 1);
    endtask

    task automatic commit_row(input string nm, input logic fl, input logic [3:0] fw,
                              input logic s, input logic l);
        add(nm, 0, fl, 0, 4'b0000, 0, 0, 0, 0, 2'd0, fw, 0, 0, s, l, 1);
    endtask

    task automatic drive(input logic mi, input logic fl, input logic iv, input logic [3:0] vw,
                         input logic di, input logic ak);
        Miss = mi; FlushStage = fl; InvalidateCache = iv; VictimWay = vw; VictimDirty = di; BusAck = ak;
    endtask

    initial begin
        int cyc;

        // Clean miss, victim 0100, ack always high
        idle_row("a_launch", 1, 0, 0, 4'b0100, 0, 4'b0000);
        for (int k = 0; k < 4; k++) fetch_row("a_fetch", 0, 0, 4'b0100, 1, k, 4'b0100, k == 0);
        commit_row("a_commit", 0, 4'b0100, 1, 1);

        // Dirty miss, victim 0001; a Miss mid-fetch is ignored
        idle_row("b_launch", 1, 0, 0, 4'b0001, 1, 4'b0100);
        for (int k = 0; k < 4; k++) wb_row("b_wb", 0, 1, k, 4'b0001);
        for (int k = 0; k < 4; k++) fetch_row("b_fetch", k == 2, 0, 4'b0001, 1, k, 4'b0001, k == 0);
        commit_row("b_commit", 0, 4'b0001, 1, 1);

        // Dirty miss with ack toggling, victim changes mid-fetch, flush in commit
        idle_row("c_launch", 1, 0, 0, 4'b0001, 1, 4'b0001);
        for (int j = 0; j < 8; j++) wb_row("c_wb", 0, logic'(j % 2), j / 2, 4'b0001);
        for (int j = 0; j < 8; j++) fetch_row("c_fetch", 0, 0, 4'b1000, logic'(j % 2), j / 2, 4'b0001, j == 0);
        commit_row("c_commit_flush", 1, 4'b0001, 1, 0);

        // Invalidate pulse during writeback suppresses the commit
        idle_row("d_launch", 1, 0, 0, 4'b0010, 1, 4'b0001);
        for (int k = 0; k < 4; k++) wb_row("d_wb", k == 0, 1, k, 4'b0010);
        for (int k = 0; k < 4; k++) fetch_row("d_fetch", 0, 0, 4'b0010, 1, k, 4'b0010, k == 0);
        commit_row("d_commit_inv", 0, 4'b0010, 0, 0);

        // Following miss commits normally
        idle_row("d2_launch", 1, 0, 0, 4'b1000, 0, 4'b0010);
        for (int k = 0; k < 4; k++) fetch_row("d2_fetch", 0, 0, 4'b1000, 1, k, 4'b1000, k == 0);
        commit_row("d2_commit", 0, 4'b1000, 1, 1);

        // No launch when invalidate or flush coincides with Miss
        idle_row("e_miss_inval", 1, 0, 1, 4'b0100, 0, 4'b1000);
        idle_row("e_after_inval", 0, 0, 0, 4'b0100, 0, 4'b1000);
        idle_row("e_miss_flush", 1, 1, 0, 4'b0100, 1, 4'b1000);
        idle_row("e_after_flush", 0, 0, 0, 4'b0100, 0, 4'b1000);

        // Invalidate on the same edge as the last fetch beat
        idle_row("f_launch", 1, 0, 0, 4'b0100, 0, 4'b1000);
        for (int k = 0; k < 4; k++) fetch_row("f_fetch", 0, k == 3, 4'b0100, 1, k, 4'b0100, k == 0);
        commit_row("f_commit_inv", 0, 4'b0100, 0, 0);
        idle_row("f_idle", 0, 0, 0, 4'b0000, 0, 4'b0100);

        drive(0, 0, 0, 4'b0000, 0, 0);
        reset = 1'b0;
        #1;
        check13("reset_outputs", outs_now(), 13'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].miss, vecs[i].flush, vecs[i].inval, vecs[i].vway, vecs[i].dirty, vecs[i].ack);
            #2;
            check13(vecs[i].name, outs_now(),
                    {vecs[i].breq, vecs[i].bwr, vecs[i].beat, vecs[i].fway,
                     vecs[i].fwe, vecs[i].cv, vecs[i].sv, vecs[i].lru, vecs[i].stall});
        end

        // Asynchronous reset during fetch beat 2
        @(negedge clk);
        drive(1, 0, 0, 4'b0010, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 4'b0010, 0, 1);
        @(negedge clk);
        @(negedge clk);
        #2;
        check13("g_fetch_beat2", outs_now(), {1'b1, 1'b0, 2'd2, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        #1;
        reset = 1'b0;
        #1;
        check13("g_async_reset", outs_now(), 13'd0);
        @(negedge clk);
        reset = 1'b1;
        BusAck = 1'b0;
        @(negedge clk);
        #2;
        check13("g_idle_after_reset", outs_now(), 13'd0);

        // Relaunch after reset and measure stall length
        drive(1, 0, 0, 4'b1000, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 4'b1000, 0, 1);
        #2;
        check13("g_relaunch", outs_now(), {1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        cyc = 1;
        while (Stall && cyc < 40) begin
            @(negedge clk);
            #2;
            if (Stall) cyc++;
        end
        check_int("g_clean_stall_cycles", cyc, BL + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
